// File: rtl/au_arbiter_if.sv
// Requester-side request/response bus and AU-side operand/result bus
// for the shared arithmetic-unit arbiter.
interface au_arbiter_if #(
    parameter int W    = 24,
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [2*NREQ-1:0] req_op;
    logic [2*NREQ-1:0] req_muly;
    logic [W*NREQ-1:0] req_r;
    logic [W*NREQ-1:0] req_s;
    logic [W*NREQ-1:0] req_imm;

    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_data;
    logic              rsp_err;
    logic [IDW-1:0]    rsp_id;

    logic              au_start;
    logic [W-1:0]      au_r;
    logic [W-1:0]      au_s;
    logic [W-1:0]      au_imm;
    logic [1:0]        au_op_sel;
    logic [1:0]        au_mul_y_sel;
    logic [W-1:0]      au_result;
    logic              au_done;
    logic              au_busy;

    modport slave (
        input  req_valid, req_op, req_muly, req_r, req_s, req_imm,
        output req_ready,
        output rsp_valid, rsp_data, rsp_err, rsp_id,
        output au_start, au_r, au_s, au_imm, au_op_sel, au_mul_y_sel,
        input  au_result, au_done, au_busy
    );

    modport master (
        output req_valid, req_op, req_muly, req_r, req_s, req_imm,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_err, rsp_id,
        input  au_start, au_r, au_s, au_imm, au_op_sel, au_mul_y_sel,
        output au_result, au_done, au_busy
    );
endinterface

// File: rtl/au_arbiter.sv
// Round-robin arbiter sharing one arithmetic unit among NREQ requesters,
// with operand hold across the AU operation and a completion watchdog.
module au_arbiter #(
    parameter int W    = 24,
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int TMO  = 64
) (
    input  logic          clk,
    input  logic          rst,
    au_arbiter_if.slave   bus,
    output logic          arb_busy
);
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW = $clog2(TMO);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  gid;
    logic [WDW-1:0] wd;
    logic [PW-1:0]  gnt;
    logic [PW-1:0]  cand;
    logic           gnt_ok;
    logic           au_busy_unused;

    assign au_busy_unused = bus.au_busy;
    assign arb_busy = (state != IDLE);

    // Walk from farthest to nearest so the candidate right after ptr wins.
    always_comb begin
        gnt_ok = 1'b0;
        gnt    = '0;
        cand   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (bus.req_valid[cand]) begin
                gnt_ok = 1'b1;
                gnt    = cand;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && gnt_ok && !rst)
            bus.req_ready[gnt] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            ptr              <= PW'(NREQ - 1);
            gid              <= '0;
            wd               <= '0;
            bus.rsp_valid    <= '0;
            bus.rsp_data     <= '0;
            bus.rsp_err      <= 1'b0;
            bus.rsp_id       <= '0;
            bus.au_start     <= 1'b0;
            bus.au_r         <= '0;
            bus.au_s         <= '0;
            bus.au_imm       <= '0;
            bus.au_op_sel    <= '0;
            bus.au_mul_y_sel <= '0;
        end else begin
            bus.au_start  <= 1'b0;
            bus.rsp_valid <= '0;
            unique case (state)
                IDLE: begin
                    if (gnt_ok) begin
                        bus.au_r         <= bus.req_r[W*gnt +: W];
                        bus.au_s         <= bus.req_s[W*gnt +: W];
                        bus.au_imm       <= bus.req_imm[W*gnt +: W];
                        bus.au_op_sel    <= bus.req_op[2*gnt +: 2];
                        bus.au_mul_y_sel <= bus.req_muly[2*gnt +: 2];
                        bus.rsp_id       <= IDW'(gnt);
                        gid              <= gnt;
                        bus.au_start     <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd    <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    wd <= wd + 1'b1;
                    // A completion in the watchdog's last cycle still counts.
                    if (bus.au_done) begin
                        bus.rsp_data  <= bus.au_result;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_valid <= NREQ'(1) << gid;
                        state         <= RESP;
                    end else if (wd == WDW'(TMO - 1)) begin
                        bus.rsp_data  <= '0;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_valid <= NREQ'(1) << gid;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    ptr   <= gid;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
